reg_writeback: RTL and testbench



---
 rtl/reg_wb_pkg.sv | 13 +
 rtl/wb_load_fifo.sv | 72 +++++++
 rtl/reg_writeback.sv | 100 ++++++++++
 tb/tb_reg_writeback.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package reg_wb_pkg;

    localparam int unsigned REG_ADR_W = 5;
    localparam int unsigned DATA_W    = 32;

    typedef struct packed {
        logic                 vld;
        logic [REG_ADR_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Circular load-data buffer with per-entry kill on a younger ALU write to the same rd.
module wb_load_fifo
    import reg_wb_pkg::*;
#(
    parameter int unsigned LD_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [REG_ADR_W-1:0] push_rd,
    input  logic [DATA_W-1:0]    push_data,
    input  logic                 pop_en,
    output wb_entry_t            head,
    output logic                 not_empty,
    input  logic                 kill_en,
    input  logic [REG_ADR_W-1:0] kill_rd
);

    localparam int unsigned PtrW = $clog2(LD_DEPTH);
    localparam int unsigned CntW = $clog2(LD_DEPTH + 1);

    wb_entry_t       mem_q [LD_DEPTH];
    wb_entry_t       mem_d [LD_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_fire;
    logic            pop_fire;

    assign push_ready = (count_q != CntW'(LD_DEPTH));
    assign not_empty  = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];

    // Beats to x0 complete the handshake but are never stored.
    assign push_fire = push_valid && push_ready && (push_rd != '0);
    assign pop_fire  = pop_en && not_empty;

    always_comb begin
        mem_d = mem_q;
        if (kill_en) begin
            for (int i = 0; i < LD_DEPTH; i++) begin
                if (mem_q[i].rd == kill_rd) begin
                    mem_d[i].vld = 1'b0;
                end
            end
        end
        if (push_fire) begin
            mem_d[wr_ptr_q].vld  = !(kill_en && (push_rd == kill_rd));
            mem_d[wr_ptr_q].rd   = push_rd;
            mem_d[wr_ptr_q].data = push_data;
        end
        wr_ptr_d = wr_ptr_q + PtrW'(push_fire);
        rd_ptr_d = rd_ptr_q + PtrW'(pop_fire);
        count_d  = count_q + CntW'(push_fire) - CntW'(pop_fire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port arbiter: ALU results first, buffered loads otherwise.
// Optional same-cycle forwarding from the write port is enabled by REG_WB_FWD_EN.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int unsigned LD_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [REG_ADR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [REG_ADR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 regwrite,
    output logic [REG_ADR_W-1:0] adr_wr_reg,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 ld_pending
`ifdef REG_WB_FWD_EN
   ,input  logic [REG_ADR_W-1:0] adr_reg1,
    input  logic [REG_ADR_W-1:0] adr_reg2,
    output logic                 fwd1_hit,
    output logic                 fwd2_hit,
    output logic [DATA_W-1:0]    fwd1_data,
    output logic [DATA_W-1:0]    fwd2_data
`endif
);

    logic                 alu_live;
    logic                 pop;
    wb_entry_t            head;
    logic                 not_empty;
    logic                 regwrite_q, regwrite_d;
    logic [REG_ADR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0]    data_q, data_d;

    assign alu_live = alu_valid && (alu_rd != '0);
    assign pop      = !alu_live && not_empty;

    wb_load_fifo #(
        .LD_DEPTH (LD_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (ld_valid),
        .push_ready (ld_ready),
        .push_rd    (ld_rd),
        .push_data  (ld_data),
        .pop_en     (pop),
        .head       (head),
        .not_empty  (not_empty),
        .kill_en    (alu_live),
        .kill_rd    (alu_rd)
    );

    // A killed head still consumes its pop cycle, with the write suppressed.
    always_comb begin
        regwrite_d = 1'b0;
        adr_d      = adr_q;
        data_d     = data_q;
        if (alu_live) begin
            regwrite_d = 1'b1;
            adr_d      = alu_rd;
            data_d     = alu_data;
        end else if (pop && head.vld) begin
            regwrite_d = 1'b1;
            adr_d      = head.rd;
            data_d     = head.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q <= 1'b0;
            adr_q      <= '0;
            data_q     <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            adr_q      <= adr_d;
            data_q     <= data_d;
        end
    end

    assign regwrite   = regwrite_q;
    assign adr_wr_reg = adr_q;
    assign wr_data    = data_q;
    assign ld_pending = not_empty;

`ifdef REG_WB_FWD_EN
    always_comb begin
        fwd1_hit  = regwrite_q && (adr_q == adr_reg1) && (adr_reg1 != '0);
        fwd2_hit  = regwrite_q && (adr_q == adr_reg2) && (adr_reg2 != '0);
        fwd1_data = data_q;
        fwd2_data = data_q;
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: per-cycle vector table plus a write scoreboard.
module tb_reg_writeback;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        regwrite;
    logic [4:0]  adr_wr_reg;
    logic [31:0] wr_data;
    logic        ld_pending;
`ifdef REG_WB_FWD_EN
    logic [4:0]  adr_reg1;
    logic [4:0]  adr_reg2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
`endif

    reg_writeback #(
        .LD_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .regwrite   (regwrite),
        .adr_wr_reg (adr_wr_reg),
        .wr_data    (wr_data),
`ifdef REG_WB_FWD_EN
        .adr_reg1   (adr_reg1),
        .adr_reg2   (adr_reg2),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data),
`endif
        .ld_pending (ld_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        rdy;
        logic        pend;
    } vec_t;

    vec_t        vecs[$];
    logic [36:0] sb[$];
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                input logic we, input logic [4:0] wrd, input logic [31:0] wdat,
                                input logic rdy, input logic pend);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.we = we; v.wrd = wrd; v.wdat = wdat;
        v.rdy = rdy; v.pend = pend;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_valid  = lv; ld_rd  = lrd; ld_data  = ldat;
    endtask

    // Every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (regwrite) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {27'd0, adr_wr_reg}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                check("sb_rd", {27'd0, adr_wr_reg}, {27'd0, e[36:32]});
                check("sb_data", wr_data, e[31:0]);
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
`ifdef REG_WB_FWD_EN
        adr_reg1 = 0;
        adr_reg2 = 0;
`endif
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_regwrite", {31'd0, regwrite}, 32'd0);
        check("rst_adr", {27'd0, adr_wr_reg}, 32'd0);
        check("rst_data", wr_data, 32'd0);
        check("rst_pending", {31'd0, ld_pending}, 32'd0);
        check("rst_ready", {31'd0, ld_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        //          av ard  adat           lv lrd ldat        we wrd wdat          rdy pend
        vecs.push_back(mk(1, 5,  32'h1234_5678, 0, 0,  0,          1, 5,  32'h1234_5678, 1, 0));
        vecs.push_back(mk(0, 0,  0,             0, 0,  0,          0, 5,  32'h1234_5678, 1, 0));
        vecs.push_back(mk(1, 10, 32'hA0,        1, 1,  32'h101,    1, 10, 32'hA0,        1, 1));
        vecs.push_back(mk(1, 11, 32'hA1,        1, 2,  32'h102,    1, 11, 32'hA1,        1, 1));
        vecs.push_back(mk(1, 12, 32'hA2,        1, 3,  32'h103,    1, 12, 32'hA2,        1, 1));
        vecs.push_back(mk(1, 13, 32'hA3,        1, 4,  32'h104,    1, 13, 32'hA3,        0, 1));
        vecs.push_back(mk(1, 14, 32'hA4,        1, 5,  32'h105,    1, 14, 32'hA4,        0, 1));
        vecs.push_back(mk(0, 0,  0,             1, 6,  32'h106,    1, 1,  32'h101,       1, 1));
        vecs.push_back(mk(0, 0,  0,             0, 0,  0,          1, 2,  32'h102,       1, 1));
        vecs.push_back(mk(0, 0,  0,             0, 0,  0,          1, 3,  32'h103,       1, 1));
        vecs.push_back(mk(0, 0,  0,             0, 0,  0,          1, 4,  32'h104,       1, 0));
        vecs.push_back(mk(0, 0,  0,             0, 0,  0,          0, 4,  32'h104,       1, 0));
        vecs.push_back(mk(0, 0,  0,             1, 7,  32'hAAAA,   0, 4,  32'h104,       1, 1));
        vecs.push_back(mk(1, 7,  32'hBBBB,      0, 0,  0,          1, 7,  32'hBBBB,      1, 1));
        vecs.push_back(mk(0, 0,  0,             0, 0,  0,          0, 7,  32'hBBBB,      1, 0));
        vecs.push_back(mk(1, 8,  32'h88,        1, 8,  32'h99,     1, 8,  32'h88,        1, 1));
        vecs.push_back(mk(0, 0,  0,             0, 0,  0,          0, 8,  32'h88,        1, 0));
        vecs.push_back(mk(1, 0,  32'h55,        1, 0,  32'h66,     0, 8,  32'h88,        1, 0));
        vecs.push_back(mk(0, 0,  0,             1, 20, 32'h200,    0, 8,  32'h88,        1, 1));
        vecs.push_back(mk(1, 0,  32'h77,        0, 0,  0,          1, 20, 32'h200,       1, 0));
        vecs.push_back(mk(1, 22, 32'h220,       1, 21, 32'h210,    1, 22, 32'h220,       1, 1));
        vecs.push_back(mk(1, 23, 32'h230,       0, 0,  0,          1, 23, 32'h230,       1, 1));
        vecs.push_back(mk(0, 0,  0,             0, 0,  0,          1, 21, 32'h210,       1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].lv, vecs[i].lrd, vecs[i].ldat);
            if (vecs[i].we) sb.push_back({vecs[i].wrd, vecs[i].wdat});
            @(negedge clk);
            check($sformatf("v%0d_regwrite", i), {31'd0, regwrite}, {31'd0, vecs[i].we});
            check($sformatf("v%0d_adr", i), {27'd0, adr_wr_reg}, {27'd0, vecs[i].wrd});
            check($sformatf("v%0d_data", i), wr_data, vecs[i].wdat);
            check($sformatf("v%0d_ready", i), {31'd0, ld_ready}, {31'd0, vecs[i].rdy});
            check($sformatf("v%0d_pending", i), {31'd0, ld_pending}, {31'd0, vecs[i].pend});
        end

        // Buffer three loads behind ALU traffic, then reset mid-stream.
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'(24 + k), 32'h240 + 32'(k), 1, 5'(1 + k), 32'h301 + 32'(k));
            sb.push_back({5'(24 + k), 32'h240 + 32'(k)});
            @(negedge clk);
        end
        check("pre_rst_pending", {31'd0, ld_pending}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_regwrite", {31'd0, regwrite}, 32'd0);
        check("mid_rst_adr", {27'd0, adr_wr_reg}, 32'd0);
        check("mid_rst_data", wr_data, 32'd0);
        check("mid_rst_pending", {31'd0, ld_pending}, 32'd0);
        check("mid_rst_ready", {31'd0, ld_ready}, 32'd1);
        drive(0, 0, 0, 1, 9, 32'h999);
        @(negedge clk);
        @(negedge clk);
        check("in_rst_push_ignored", {31'd0, ld_pending}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("post_rst_pending", {31'd0, ld_pending}, 32'd0);
        check("post_rst_regwrite", {31'd0, regwrite}, 32'd0);

`ifdef REG_WB_FWD_EN
        drive(1, 9, 32'hCAFE_F00D, 0, 0, 0);
        sb.push_back({5'd9, 32'hCAFE_F00D});
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        adr_reg1 = 9;
        adr_reg2 = 0;
        #1;
        check("fwd1_hit", {31'd0, fwd1_hit}, 32'd1);
        check("fwd1_data", fwd1_data, 32'hCAFE_F00D);
        check("fwd2_hit", {31'd0, fwd2_hit}, 32'd0);
        @(negedge clk);
        #1;
        check("fwd1_hit_idle", {31'd0, fwd1_hit}, 32'd0);
`endif

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
